// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 5x4 push-button matrix on a slow scan clock. One scan line (keyX)
// is pulled low per cycle, the four return lines (keyY) are sampled, and the
// 20 samples of a full round are reduced to NONE / single KEY / multi-press
// (treated as NONE). Round results pass through a debounce filter before
// being committed to keyCode / ready.
//
// Build option:
//   KEYPAD_DEBOUNCE_EN defined     : a result must repeat DEBOUNCE rounds
//                                    before it is committed.
//   KEYPAD_DEBOUNCE_EN not defined : every round result is committed at its
//                                    column-4 edge; DEBOUNCE is ignored.
//
// Column sequencer:
//   state (col) | meaning
//   0..3        | drive keyX[col] low, store ~keyY as that column's row mask
//   4           | drive keyX[4] low, evaluate round, update debounce/outputs
module keypad_scanner #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire  [4:0] keyX,
  inout  wire  [3:0] keyY,
  output logic [4:0] keyCode,
  output logic       ready
);

  localparam logic [2:0] LAST_COL = 3'd4;

  // Out-of-range debounce depths cannot be represented by the 4-bit counter.
  if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE must be in 1..15");
  end

  logic [2:0]  col;
  logic [2:0]  col_d;
  logic [4:0]  drive_x;
  logic [15:0] mask_q;
  logic [3:0]  row_now;
  logic [19:0] round_mask;
  logic [4:0]  hit_cnt;
  logic [4:0]  hit_code;
  logic        res_key;
  logic [4:0]  res_code;
  logic        round_end;
  logic        commit;

  // Return lines are only ever read; external pull-ups define the idle level.
  assign keyY = 4'bzzzz;

  // Open-drain scan lines: an enabled line is pulled to 0, the rest float.
  for (genvar i = 0; i < 5; i++) begin : g_drive
    assign keyX[i] = drive_x[i] ? 1'b0 : 1'bz;
  end

  assign row_now   = ~keyY;
  assign round_end = (col == LAST_COL);

  // Column state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= 3'd0;
    end else begin
      col <= col_d;
    end
  end

  // Next column: walk 0..4 and wrap.
  always_comb begin
    col_d = 3'd0;
    if (col < LAST_COL) begin
      col_d = col + 3'd1;
    end
  end

  // Scan-line enables; column 0 is held active throughout reset so the pads
  // see a defined pattern even before the first reset edge.
  always_comb begin
    drive_x = 5'b00000;
    if (!rst_n) begin
      drive_x[0] = 1'b1;
    end else begin
      case (col)
        3'd0:    drive_x[0] = 1'b1;
        3'd1:    drive_x[1] = 1'b1;
        3'd2:    drive_x[2] = 1'b1;
        3'd3:    drive_x[3] = 1'b1;
        3'd4:    drive_x[4] = 1'b1;
        default: drive_x = 5'b00000;
      endcase
    end
  end

  // Row masks for columns 0..3; column 4 is used live at the round edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= 16'h0000;
    end else begin
      case (col)
        3'd0:    mask_q[3:0]   <= row_now;
        3'd1:    mask_q[7:4]   <= row_now;
        3'd2:    mask_q[11:8]  <= row_now;
        3'd3:    mask_q[15:12] <= row_now;
        default: mask_q        <= mask_q;
      endcase
    end
  end

  assign round_mask = {row_now, mask_q};

  // Round reduction: count pressed keys and remember the index of one of them.
  always_comb begin
    hit_cnt  = 5'd0;
    hit_code = 5'd0;
    for (int i = 0; i < 20; i++) begin
      if (round_mask[i]) begin
        hit_cnt  = hit_cnt + 5'd1;
        hit_code = 5'(i);
      end
    end
  end

  assign res_key  = (hit_cnt == 5'd1);
  assign res_code = hit_code;

`ifdef KEYPAD_DEBOUNCE_EN
  localparam logic [3:0] DB = 4'(DEBOUNCE);

  logic       prev_key;
  logic [4:0] prev_code;
  logic [3:0] stable;
  logic [3:0] stable_d;
  logic       same;

  // NONE results compare equal regardless of the code field.
  assign same = (res_key == prev_key) && (!res_key || (res_code == prev_code));

  // Saturating run length of the current round result.
  always_comb begin
    stable_d = 4'd1;
    if (same) begin
      stable_d = (stable >= DB) ? DB : stable + 4'd1;
    end
  end

  assign commit = (stable_d == DB);

  // Debounce history, advanced once per round.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_key  <= 1'b0;
      prev_code <= 5'd0;
      stable    <= 4'd0;
    end else if (round_end) begin
      prev_key  <= res_key;
      prev_code <= res_code;
      stable    <= stable_d;
    end
  end
`else
  assign commit = 1'b1;
`endif

  // Committed outputs; keyCode keeps the last key across releases.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready   <= 1'b0;
      keyCode <= 5'd0;
    end else if (round_end && commit) begin
      ready <= res_key;
      if (res_key) begin
        keyCode <= res_code;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model on the pads, a round-level
// reference of the debounce behaviour, and a queue of expected outputs
// consumed at each column-4 edge.
module tb_keypad_scanner;

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int EFF = 4;
`else
  localparam int EFF = 1;
`endif

  typedef struct packed {
    logic       rdy;
    logic [4:0] code;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  wire  [4:0]  key_x;
  wire  [3:0]  key_y;
  logic [4:0]  key_code;
  logic        ready;
  logic [19:0] press = 20'h0;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   col_m = 0;

  logic       m_pk;
  logic [4:0] m_pc;
  int         m_run;
  logic       m_ready;
  logic [4:0] m_kc;

  keypad_scanner #(.DEBOUNCE(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .keyX    (key_x),
    .keyY    (key_y),
    .keyCode (key_code),
    .ready   (ready)
  );

  pullup pu0 (key_x[0]);
  pullup pu1 (key_x[1]);
  pullup pu2 (key_x[2]);
  pullup pu3 (key_x[3]);
  pullup pu4 (key_x[4]);

  // Matrix: a return line reads 0 when a pressed key connects it to a low scan line.
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign key_y[r] = ~((press[r]      & ~key_x[0]) |
                        (press[4 + r]  & ~key_x[1]) |
                        (press[8 + r]  & ~key_x[2]) |
                        (press[12 + r] & ~key_x[3]) |
                        (press[16 + r] & ~key_x[4]));
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pk    = 1'b0;
    m_pc    = 5'd0;
    m_run   = 0;
    m_ready = 1'b0;
    m_kc    = 5'd0;
  endtask

  // Expected committed outputs after one round with key set p.
  task automatic model_round(input logic [19:0] p);
    int         n;
    logic       k;
    logic [4:0] c;
    n = 0;
    c = 5'd0;
    for (int i = 0; i < 20; i++) begin
      if (p[i]) begin
        n++;
        c = 5'(i);
      end
    end
    k = (n == 1);
    if ((k == m_pk) && (!k || c == m_pc)) begin
      if (m_run < EFF) m_run++;
    end else begin
      m_pk  = k;
      m_pc  = c;
      m_run = 1;
    end
    if (m_run == EFF) begin
      m_ready = k;
      if (k) m_kc = c;
    end
    sb_q.push_back('{rdy: m_ready, code: m_kc});
  endtask

  // One full scan round with key set p held; checks every cycle.
  task automatic run_round(input logic [19:0] p);
    logic       pr;
    logic [4:0] pc;
    logic [4:0] ex;
    exp_t       e;
    pr = m_ready;
    pc = m_kc;
    press = p;
    model_round(p);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      col_m = (col_m == 4) ? 0 : col_m + 1;
      ex = ~(5'b00001 << col_m);
      check("key_x", {3'b0, key_x}, {3'b0, ex});
      if (i < 4) begin
        check("ready_hold", {7'b0, ready}, {7'b0, pr});
        check("code_hold", {3'b0, key_code}, {3'b0, pc});
      end else begin
        if (sb_q.size() == 0) begin
          check("sb_empty", 8'd1, 8'd0);
        end else begin
          e = sb_q.pop_front();
          check("ready", {7'b0, ready}, {7'b0, e.rdy});
          check("key_code", {3'b0, key_code}, {3'b0, e.code});
        end
      end
    end
  endtask

  task automatic rounds(input logic [19:0] p, input int n);
    for (int i = 0; i < n; i++) run_round(p);
  endtask

  function automatic logic [19:0] key(input int k);
    logic [19:0] one;
    one = 20'h1;
    return one << k;
  endfunction

  initial begin
    model_reset();
    rst_n = 1'b0;
    press = 20'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {7'b0, ready}, 8'd0);
    check("rst_code", {3'b0, key_code}, 8'd0);
    check("rst_key_x", {3'b0, key_x}, 8'h1e);
    col_m = 0;
    rst_n = 1'b1;

    rounds(20'h0, 2);

    // Key 4 (col 1, row 0): press then release; keyCode must stay 4.
    rounds(key(4), 6);
    rounds(20'h0, 5);

    // Key 9 (col 2, row 1).
    rounds(key(9), 6);
    rounds(20'h0, 5);

    // Bounce: 2 pressed, 1 released, 4 pressed.
    rounds(key(9), 2);
    rounds(20'h0, 1);
    rounds(key(9), 4);
    rounds(20'h0, 5);

    // Multi-press rejected, then the remaining single key wins.
    rounds(key(0) | key(5), 8);
    rounds(key(0), 5);
    rounds(20'h0, 5);

    // Direct key change without release.
    rounds(key(4), 5);
    rounds(key(19), 5);
    rounds(20'h0, 5);

    // Short press never commits when debouncing.
    rounds(key(7), 3);
    rounds(20'h0, 5);

    // Reset while a key is committed.
    rounds(key(4), 5);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_ready", {7'b0, ready}, 8'd0);
    check("mid_rst_code", {3'b0, key_code}, 8'd0);
    check("mid_rst_key_x", {3'b0, key_x}, 8'h1e);
    model_reset();
    col_m = 0;
    rst_n = 1'b1;
    rounds(key(4), 5);
    rounds(20'h0, 5);

    // Single round of key 19.
    rounds(key(19), 1);
    rounds(20'h0, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
